// File: rtl/sr_arb_pkg.sv
// Shared types and helpers for the SR latch arbiter.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } arb_state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    // Width of the shared down-counter. It is loaded with (cycles - 1),
    // so it must hold max(pulse, settle) - 1.
    function automatic int cnt_width(input int pulse_cycles, input int settle_cycles);
        int m;
        m = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sr_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr,
// wrapping modulo N_REQ.
module sr_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [IW-1:0]    idx
);

    assign any = |req_valid;

    // Walk the ring from farthest to nearest so the nearest valid index wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req_valid[j]) begin
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that is the sole driver of a gated SR latch.
// Handshake: a requester raises req_valid with a stable req_op and holds it
// until its one-cycle req_ack; requests are only sampled while in IDLE and a
// granted transaction completes with an ack even if req_valid drops early.
module sr_latch_arbiter
    import sr_arb_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int PULSE_CYCLES  = 2,
    parameter  int SETTLE_CYCLES = 2,
    localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_op,
    output logic [N_REQ-1:0] req_ack,
    output logic [IW-1:0]    grant_id,
    output logic             busy,
    output logic             S,
    output logic             R,
    input  logic             Q,
    output logic             err,
    output arb_state_t       dbg_state
);

    localparam int CW = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);

    arb_state_t       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IW-1:0]    ptr, ptr_nx;
    logic [IW-1:0]    gid_nx;
    logic             op, op_nx;
    logic             err_nx;
    logic             s_nx, r_nx;
    logic [N_REQ-1:0] ack_nx;
    logic             q_meta, q_s;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;

    sr_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .any       (pick_any),
        .idx       (pick_idx)
    );

    assign dbg_state = state;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        gid_nx   = grant_id;
        op_nx    = op;
        err_nx   = err;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    gid_nx = pick_idx;
                    op_nx  = req_op[pick_idx];
                    if (q_s == op_nx) begin
                        // Latch already holds the requested value: no pulse.
                        state_nx = CHECK;
                    end else begin
                        state_nx = DRIVE;
                        cnt_nx   = CW'(PULSE_CYCLES - 1);
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    state_nx = SETTLE;
                    cnt_nx   = CW'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            CHECK: begin
                if (q_s != op) begin
                    err_nx = 1'b1;
                end
                ptr_nx   = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // S and R both derive from DRIVE and differ only by op, so they can
        // never be high together.
        s_nx   = (state_nx == DRIVE) && (op_nx == OP_SET);
        r_nx   = (state_nx == DRIVE) && (op_nx == OP_RESET);
        ack_nx = '0;
        if (state_nx == CHECK) begin
            ack_nx[gid_nx] = 1'b1;
        end
    end

    // State, counter, pointer, synchronizer and output registers.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            grant_id <= '0;
            op       <= OP_RESET;
            err      <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            req_ack  <= '0;
            busy     <= 1'b0;
            q_meta   <= 1'b0;
            q_s      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ptr      <= ptr_nx;
            grant_id <= gid_nx;
            op       <= op_nx;
            err      <= err_nx;
            S        <= s_nx;
            R        <= r_nx;
            req_ack  <= ack_nx;
            busy     <= (state_nx != IDLE);
            q_meta   <= Q;
            q_s      <= q_meta;
        end
    end

endmodule

// File: doc/sr_latch_arbiter.md
# sr_latch_arbiter

Shares one gated SR latch (set/reset storage cell, clock-gated S/R inputs) among N_REQ requesters. Each requester asks to set or reset the latch; the block grants one request at a time in round-robin order, drives a clean S or R pulse (never both), waits for the latch to settle, checks the latched Q against the requested value, and acknowledges. It sits between the lab's request logic and the SR cell and is the only driver of the cell's S and R inputs.

## Interface
- N_REQ, 4: number of requesters (2..8).
- PULSE_CYCLES, 2: cycles S or R is held high per write (>=1).
- SETTLE_CYCLES, 2: idle cycles after the pulse before Q is checked (>=2, covers the Q synchronizer).
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst_n  in  1  synchronous, active-low reset, sampled on the rising Clk edge.
- req_valid  in  N_REQ  per-requester request; held until that requester's ack.
- req_op  in  N_REQ  per-requester op; 1 = set (Q->1), 0 = reset (Q->0); stable while valid.
- req_ack  out  N_REQ  one-hot, single-cycle completion pulse.
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- S  out  1  set drive to the latch.
- R  out  1  reset drive to the latch.
- Q  in  1  latch output, asynchronous to Clk.
- err  out  1  sticky flag: Q mismatched the requested value at a check.

## Operation
- Q passes through a 2-flop synchronizer to give q_s. All decisions use q_s.
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE
  - If any req_valid is high, pick the first valid index at or after ptr, wrapping modulo N_REQ.
  - Register grant_id and op.
  - If q_s already equals op, go to CHECK (short-circuit, no pulse).
  - Otherwise go to DRIVE.
- DRIVE
  - Assert S when op=1, or R when op=0, for exactly PULSE_CYCLES cycles, then go to SETTLE.
- SETTLE
  - Hold S=R=0 for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (one cycle)
  - Pulse req_ack[grant_id].
  - If q_s != op, set err.
  - Set ptr = grant_id+1 (mod N_REQ).
  - Return to IDLE.
- S and R are registered outputs and are never high together. No state or input combination may produce S&R.
- If a requester drops req_valid before its ack, the transaction still completes and the ack is still issued.
- New requests are sampled only in IDLE.
- err clears only on reset.

## Timing
- Reset values: S=0, R=0, req_ack=0, busy=0, err=0, grant_id=0, ptr=0, state IDLE, synchronizer flops 0.
- Take cycle 0 as the IDLE edge that samples a request.
  - S/R high in cycles 1..PULSE_CYCLES.
  - ack in cycle PULSE_CYCLES+SETTLE_CYCLES+1 (cycle 5 with defaults).
  - IDLE again the following cycle.
- Short-circuit path: ack in cycle 1, S and R stay low throughout.
- Back-to-back requests: each transaction costs PULSE_CYCLES+SETTLE_CYCLES+2 cycles from one grant to the next. A short-circuit transaction costs 2 cycles.
- Rst_n low in any state: at that edge, state returns to IDLE and all outputs take their reset values. No ack is issued for an interrupted transaction.
- Q may change at any time. Only q_s sampled in IDLE (short-circuit decision) and in CHECK (error check) has any effect.

## Structure
- Package sr_arb_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, CHECK);
  - OP_SET=1'b1, OP_RESET=1'b0;
  - a width function for the cycle counter, max(PULSE_CYCLES, SETTLE_CYCLES).
- Sub-module sr_rr_pick: combinational round-robin picker.
  - Inputs: req_valid, ptr.
  - Outputs: any, idx.
- Top level holds the FSM, one shared down-counter, the synchronizer and the output registers.
- The bench pairs the DUT with a behavioural SR latch model that has gate delay.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with req_valid=4'b1111 -> all outputs 0, no ack, S=R=0.
- Single set: Q=0, req_valid=4'b0010, req_op=4'b0010 -> grant_id=1; S high in cycles 1-2, R=0; req_ack=4'b0010 in cycle 5; Q=1; err=0.
- Contention: req0 set and req2 reset raised in the same cycle after reset -> req0 served first (ack at cycle 5), then req2 (R pulse, ack at cycle 11); S&R never high.
- Short-circuit: Q=1, req3 set -> req_ack=4'b1000 in cycle 1; S and R never asserted.
- Fault: latch model stuck at Q=0, req0 set -> S pulse, ack in cycle 5, err=1 and err stays 1 through later good transactions until reset.
- Mid-operation reset: Rst_n=0 in cycle 1 of a DRIVE -> S=0 after that edge, no ack, busy=0; a new request after release is served from ptr=0.
